sr_latch_driver: RTL and testbench



---
 rtl/sr_drv_pkg.sv | 33 +++
 rtl/sr_latch_driver_bit_sync.sv | 35 +++
 rtl/sr_latch_driver.sv | 200 ++++++++++++++++++++
 tb/tb_sr_latch_driver.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sr_drv_pkg.sv
// -----------------------------------------------------------------------------
// sr_drv_pkg
// Shared types and helpers for the SR latch driver.
//   sr_state_e : controller states (INIT, PULSE, DEAD, CHECK, IDLE)
//   max_u      : larger of two unsigned values
//   cnt_width  : width of the shared pulse/dead down-counter
// -----------------------------------------------------------------------------
package sr_drv_pkg;

   typedef enum logic [2:0] {
      ST_INIT,
      ST_PULSE,
      ST_DEAD,
      ST_CHECK,
      ST_IDLE
   } sr_state_e;

   localparam int unsigned DEF_PULSE_W     = 4;
   localparam int unsigned DEF_DEAD_W      = 3;
   localparam int unsigned DEF_SYNC_STAGES = 2;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

   // One counter serves both the pulse and the dead-time phases, so it must
   // hold the larger of the two load values.
   function automatic int unsigned cnt_width(input int unsigned pulse_w,
                                             input int unsigned dead_w);
      return $clog2(max_u(pulse_w, dead_w) + 1);
   endfunction

endpackage : sr_drv_pkg

// File: rtl/sr_latch_driver_bit_sync.sv
// -----------------------------------------------------------------------------
// bit_sync
// Multi-stage synchronizer for a single asynchronous bit.
//   clk    : destination clock
//   rst_n  : asynchronous active-low reset, clears every stage to 0
//   d_in   : asynchronous input
//   d_out  : synchronized output (last stage)
// -----------------------------------------------------------------------------
module bit_sync #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_in,
   output logic d_out
);

   logic [STAGES-1:0] sync_d;
   logic [STAGES-1:0] sync_q;

   always_comb begin
      sync_d = {sync_q[STAGES-2:0], d_in};
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync_q <= '0;
      end else begin
         sync_q <= sync_d;
      end
   end

   assign d_out = sync_q[STAGES-1];

endmodule : bit_sync

// File: rtl/sr_latch_driver.sv
// -----------------------------------------------------------------------------
// sr_latch_driver
// Writer for a cross-coupled NOR SR latch. Turns valid/ready "set level"
// requests into a single fixed-width S or R pulse followed by a dead time,
// then checks the synchronized latch readback against the expected level.
// After reset an R pulse forces the latch to a known Q=0.
//
// Ports
//   clk        : system clock, rising edge
//   rst_n      : asynchronous active-low reset
//   req_valid  : write request valid
//   req_ready  : driver can accept a request (IDLE only)
//   req_level  : desired latch Q value
//   s_out      : latch S input, registered
//   r_out      : latch R input, registered
//   q_in       : latch Q readback, asynchronous
//   level      : expected latch state
//   done       : one-cycle completion strobe
//   err        : sticky mismatch/upset flag
//   err_clr    : clears err (a simultaneous set wins)
// -----------------------------------------------------------------------------
module sr_latch_driver
   import sr_drv_pkg::*;
#(
   parameter int unsigned PULSE_W     = DEF_PULSE_W,
   parameter int unsigned DEAD_W      = DEF_DEAD_W,
   parameter int unsigned SYNC_STAGES = DEF_SYNC_STAGES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic req_valid,
   output logic req_ready,
   input  logic req_level,
   output logic s_out,
   output logic r_out,
   input  logic q_in,
   output logic level,
   output logic done,
   output logic err,
   input  logic err_clr
);

   localparam int unsigned CNT_W = cnt_width(PULSE_W, DEAD_W);
   localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(PULSE_W);
   localparam logic [CNT_W-1:0] DEAD_LD  = CNT_W'(DEAD_W);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   // ---------------------------------------------------------------------
   // Elaboration-time parameter checks
   // ---------------------------------------------------------------------
   if (PULSE_W < 1) begin : g_bad_pulse_w
      $error("sr_latch_driver: PULSE_W must be >= 1");
   end
   if (SYNC_STAGES < 2) begin : g_bad_sync_stages
      $error("sr_latch_driver: SYNC_STAGES must be >= 2");
   end
   // The readback must have crossed the synchronizer before CHECK samples it.
   if (DEAD_W < SYNC_STAGES + 1) begin : g_bad_dead_w
      $error("sr_latch_driver: DEAD_W must be >= SYNC_STAGES+1");
   end

   // ---------------------------------------------------------------------
   // Readback synchronizer
   // ---------------------------------------------------------------------
   logic q_sync;

   bit_sync #(
      .STAGES (SYNC_STAGES)
   ) u_q_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_in  (q_in),
      .d_out (q_sync)
   );

   // ---------------------------------------------------------------------
   // Controller state
   // ---------------------------------------------------------------------
   sr_state_e        state_d,     state_q;
   logic [CNT_W-1:0] cnt_d,       cnt_q;
   logic             s_out_d,     s_out_q;
   logic             r_out_d,     r_out_q;
   logic             req_ready_d, req_ready_q;
   logic             level_d,     level_q;
   logic             done_d,      done_q;
   logic             err_d,       err_q;
   logic             err_set;
   logic             accept;
   logic             mismatch;

   assign accept   = req_valid && req_ready_q;
   assign mismatch = (q_sync != level_q);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      s_out_d     = s_out_q;
      r_out_d     = r_out_q;
      level_d     = level_q;
      req_ready_d = 1'b0;
      done_d      = 1'b0;
      err_set     = 1'b0;

      unique case (state_q)
         ST_INIT: begin
            // Drive R so the latch starts from a known Q=0.
            state_d = ST_PULSE;
            s_out_d = 1'b0;
            r_out_d = 1'b1;
            level_d = 1'b0;
            cnt_d   = PULSE_LD;
         end

         ST_PULSE: begin
            if (cnt_q <= CNT_ONE) begin
               state_d = ST_DEAD;
               s_out_d = 1'b0;
               r_out_d = 1'b0;
               cnt_d   = DEAD_LD;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end

         ST_DEAD: begin
            if (cnt_q <= CNT_ONE) begin
               state_d = ST_CHECK;
               done_d  = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_ONE;
            end
         end

         ST_CHECK: begin
            err_set     = mismatch;
            state_d     = ST_IDLE;
            req_ready_d = 1'b1;
         end

         ST_IDLE: begin
            // Any readback disagreement while idle is a spontaneous upset.
            err_set     = mismatch;
            req_ready_d = 1'b1;
            if (accept) begin
               if (req_level != level_q) begin
                  state_d     = ST_PULSE;
                  level_d     = req_level;
                  s_out_d     = req_level;
                  r_out_d     = ~req_level;
                  cnt_d       = PULSE_LD;
                  req_ready_d = 1'b0;
               end else begin
                  // Latch already holds the requested level: complete at once.
                  done_d = 1'b1;
               end
            end
         end

         default: begin
            state_d = ST_INIT;
            s_out_d = 1'b0;
            r_out_d = 1'b0;
            cnt_d   = '0;
         end
      endcase

      // Set has priority over clear.
      err_d = err_set | (err_q & ~err_clr);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_INIT;
         cnt_q       <= '0;
         s_out_q     <= 1'b0;
         r_out_q     <= 1'b0;
         req_ready_q <= 1'b0;
         level_q     <= 1'b0;
         done_q      <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         s_out_q     <= s_out_d;
         r_out_q     <= r_out_d;
         req_ready_q <= req_ready_d;
         level_q     <= level_d;
         done_q      <= done_d;
         err_q       <= err_d;
      end
   end

   assign s_out     = s_out_q;
   assign r_out     = r_out_q;
   assign req_ready = req_ready_q;
   assign level     = level_q;
   assign done      = done_q;
   assign err       = err_q;

endmodule : sr_latch_driver

// File: tb/tb_sr_latch_driver.sv
// -----------------------------------------------------------------------------
// tb_sr_latch_driver
// Scoreboard bench for sr_latch_driver with a behavioural NOR latch on the
// S/R outputs. The driver process pushes the expected outcome of every write
// (final level, S/R pulse widths, completion latency, err afterwards); the
// monitor pops one entry per done strobe and compares.
// -----------------------------------------------------------------------------
module tb_sr_latch_driver;

   localparam int unsigned P = 4;
   localparam int unsigned D = 3;
   localparam int unsigned S = 2;

   logic clk       = 1'b0;
   logic rst_n     = 1'b0;
   logic req_valid = 1'b0;
   logic req_level = 1'b0;
   logic err_clr   = 1'b0;
   logic q_in;
   logic req_ready, s_out, r_out, level, done, err;

   // Behavioural NOR latch; powers up holding 1 so the INIT pulse matters.
   logic latch_q   = 1'b1;
   logic force_en  = 1'b0;
   logic force_val = 1'b0;

   always @(s_out or r_out) begin
      if (s_out && !r_out) latch_q = 1'b1;
      else if (r_out && !s_out) latch_q = 1'b0;
   end

   assign q_in = force_en ? force_val : latch_q;

   sr_latch_driver #(
      .PULSE_W     (P),
      .DEAD_W      (D),
      .SYNC_STAGES (S)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_level (req_level),
      .s_out     (s_out),
      .r_out     (r_out),
      .q_in      (q_in),
      .level     (level),
      .done      (done),
      .err       (err),
      .err_clr   (err_clr)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      bit lvl;
      int s_w;
      int r_w;
      int lat;
      bit err;
      int acc;
   } exp_t;

   exp_t sb[$];
   int   checks = 0;
   int   errors = 0;
   bit   m_level = 1'b0;

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------------------------------------------------------------
   // Monitor: pulse-width accounting and scoreboard pop on done
   // ---------------------------------------------------------------------
   initial begin
      int  s_cnt;
      int  r_cnt;
      bit  err_pend;
      bit  err_exp;
      exp_t e;
      s_cnt = 0; r_cnt = 0; err_pend = 0; err_exp = 0;
      forever begin
         @(negedge clk);
         if (s_out && r_out) begin
            checks++;
            errors++;
            $display("FAIL s_r_overlap: s_out=%0b r_out=%0b required never both 1", s_out, r_out);
         end
         if (!rst_n) begin
            s_cnt = 0; r_cnt = 0; err_pend = 0;
         end else begin
            if (err_pend) begin
               chk("err_after_done", int'(err), int'(err_exp));
               err_pend = 0;
            end
            if (s_out) s_cnt++;
            if (r_out) r_cnt++;
            if (done) begin
               if (sb.size() == 0) begin
                  checks++;
                  errors++;
                  $display("FAIL unexpected_done: done=1 with empty scoreboard (cycle %0d)", cyc);
               end else begin
                  e = sb.pop_front();
                  chk("done_level", int'(level), int'(e.lvl));
                  chk("s_width", s_cnt, e.s_w);
                  chk("r_width", r_cnt, e.r_w);
                  chk("done_latency", cyc - e.acc, e.lat);
                  if (!force_en) chk("latch_q", int'(latch_q), int'(e.lvl));
                  err_pend = 1;
                  err_exp  = e.err;
               end
               s_cnt = 0; r_cnt = 0;
            end
         end
      end
   end

   // ---------------------------------------------------------------------
   // Driver helpers
   // ---------------------------------------------------------------------
   task automatic wait_ready(input int exp_cyc, input string name);
      int n;
      n = 0;
      while (!req_ready && n < 60) begin
         @(negedge clk);
         n++;
      end
      if (!req_ready) begin
         checks++;
         errors++;
         $display("FAIL %s: req_ready timeout, got 0 after %0d cycles, expected 1", name, n);
      end else begin
         chk(name, cyc, exp_cyc);
      end
   endtask

   task automatic push_init(input int acc);
      exp_t e;
      e.lvl = 1'b0; e.s_w = 0; e.r_w = P; e.lat = P + D; e.err = 1'b0; e.acc = acc;
      sb.push_back(e);
      m_level = 1'b0;
   endtask

   // Called at a negedge with req_ready=1.
   task automatic do_req(input bit lvl, input bit exp_err, input bit glitch);
      exp_t e;
      int   acc;
      bit   pulse;
      req_valid = 1'b1;
      req_level = lvl;
      acc       = cyc + 1;
      pulse     = (lvl != m_level);
      e.lvl = lvl;
      e.s_w = (pulse && lvl)  ? P : 0;
      e.r_w = (pulse && !lvl) ? P : 0;
      e.lat = pulse ? P + D : 0;
      e.err = exp_err;
      e.acc = acc;
      sb.push_back(e);
      m_level = lvl;
      @(negedge clk);
      req_valid = 1'b0;
      if (pulse) begin
         chk("ready_drop", int'(req_ready), 0);
         if (glitch) begin
            // A request offered while busy must leave no trace.
            repeat ($urandom_range(1, P + D - 2)) @(negedge clk);
            req_valid = 1'b1;
            req_level = 1'($urandom_range(0, 1));
            @(negedge clk);
            req_valid = 1'b0;
         end
         wait_ready(acc + P + D + 1, "ready_time");
      end else begin
         chk("noop_ready_kept", int'(req_ready), 1);
      end
   endtask

   // ---------------------------------------------------------------------
   // Stimulus
   // ---------------------------------------------------------------------
   initial begin
      int acc;

      // Reset state
      repeat (3) @(negedge clk);
      chk("rst_s_out", int'(s_out), 0);
      chk("rst_r_out", int'(r_out), 0);
      chk("rst_ready", int'(req_ready), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_err", int'(err), 0);
      chk("rst_level", int'(level), 0);

      // Release: INIT R pulse
      push_init(cyc + 1);
      acc   = cyc + 1;
      rst_n = 1'b1;
      wait_ready(acc + P + D + 1, "init_ready_time");
      chk("init_level", int'(level), 0);
      chk("init_err", int'(err), 0);

      // Set to 1, then a no-op write of 1
      do_req(1'b1, 1'b0, 1'b0);
      chk("set_level", int'(level), 1);
      @(negedge clk);
      do_req(1'b1, 1'b0, 1'b0);

      // Random writes with idle gaps and ignored requests while busy
      for (int i = 0; i < 40; i++) begin
         repeat ($urandom_range(0, 3)) @(negedge clk);
         do_req(1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)));
      end
      @(negedge clk);

      // Latch readback stuck at 0: CHECK flags it; clear loses to a live upset
      if (m_level) begin
         do_req(1'b0, 1'b0, 1'b0);
         @(negedge clk);
      end
      force_en  = 1'b1;
      force_val = 1'b0;
      do_req(1'b1, 1'b1, 1'b0);
      chk("stuck_err", int'(err), 1);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk("clr_vs_set", int'(err), 1);

      // Recover, then an idle upset detected after SYNC_STAGES+1 edges
      force_en = 1'b0;
      repeat (S + 1) @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk("recover_clr", int'(err), 0);
      force_en = 1'b1;
      repeat (S) @(negedge clk);
      chk("upset_early", int'(err), 0);
      @(negedge clk);
      chk("upset_detect", int'(err), 1);
      force_en = 1'b0;
      repeat (S + 1) @(negedge clk);
      err_clr = 1'b1;
      @(negedge clk);
      err_clr = 1'b0;
      chk("upset_clear", int'(err), 0);

      // Reset in the middle of an S pulse
      do_req(1'b0, 1'b0, 1'b0);
      @(negedge clk);
      req_valid = 1'b1;
      req_level = 1'b1;
      @(negedge clk);
      req_valid = 1'b0;
      @(posedge clk);
      #2;
      chk("s_before_reset", int'(s_out), 1);
      rst_n = 1'b0;
      #1;
      chk("async_s_drop", int'(s_out), 0);
      chk("async_r_low", int'(r_out), 0);
      chk("async_ready", int'(req_ready), 0);
      chk("async_level", int'(level), 0);
      sb.delete();
      @(negedge clk);
      @(negedge clk);
      push_init(cyc + 1);
      acc   = cyc + 1;
      rst_n = 1'b1;
      wait_ready(acc + P + D + 1, "reinit_ready_time");
      chk("reinit_level", int'(level), 0);
      chk("reinit_err", int'(err), 0);

      repeat (3) @(negedge clk);
      chk("sb_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation still running at cycle %0d, expected to finish", cyc);
      $fatal(1, "watchdog");
   end

endmodule : tb_sr_latch_driver
